vrf_read_sequencer: RTL and testbench

//  Drives one vrf read port (raddr/ren/oreg_en) for a whole vector-operand read and returns the read

---
 rtl/vrf_read_sequencer_if.sv | 43 ++++
 rtl/vrf_read_sequencer.sv | 141 ++++++++++++++
 tb/tb_vrf_read_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vrf_read_sequencer_if.sv
// rtl/vrf_read_sequencer_if.sv - request, vrf read-port and output-stream bundle for vrf_read_sequencer
//
// Purpose: groups every signal of one sequencer instance except clk/rstn.
// Ports (master = sequencer side, slave = issue logic / vrf / lane ALU side):
//   start_i, vs_i, len_i       request strobe, source vreg, row count
//   busy_o, done_o             request in progress, 1-cycle completion pulse
//   raddr_o, ren_o, oreg_en_o  vrf read port controls
//   dout_i                     vrf read data
//   m_data_o, m_valid_o,
//   m_last_o, m_ready_i        valid/ready output stream
interface vrf_read_sequencer_if #(
  parameter int MEM_DEPTH = 512,
  parameter int MEM_WIDTH = 32,
  parameter int VREG_NUM  = 32,
  parameter int LEN_W     = 8
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int VW = $clog2(VREG_NUM);

  logic                 start_i;
  logic [VW-1:0]        vs_i;
  logic [LEN_W-1:0]     len_i;
  logic                 busy_o;
  logic                 done_o;
  logic [AW-1:0]        raddr_o;
  logic                 ren_o;
  logic                 oreg_en_o;
  logic [MEM_WIDTH-1:0] dout_i;
  logic [MEM_WIDTH-1:0] m_data_o;
  logic                 m_valid_o;
  logic                 m_last_o;
  logic                 m_ready_i;

  modport master (
    input  start_i, vs_i, len_i, dout_i, m_ready_i,
    output busy_o, done_o, raddr_o, ren_o, oreg_en_o, m_data_o, m_valid_o, m_last_o
  );

  modport slave (
    output start_i, vs_i, len_i, dout_i, m_ready_i,
    input  busy_o, done_o, raddr_o, ren_o, oreg_en_o, m_data_o, m_valid_o, m_last_o
  );
endinterface

// File: rtl/vrf_read_sequencer.sv
// rtl/vrf_read_sequencer.sv - sequences one vrf read port for a whole vector operand into a valid/ready stream
//
// Purpose: on an accepted request, issues len_i consecutive row reads starting at vs_i*ROWS_PER_VREG
// (wrapping at MEM_DEPTH), hides the vrf's registered read latency and buffers read data in a small
// FIFO. A read is only issued while FIFO entries plus reads in flight leave room, so ALU backpressure
// can never overflow the FIFO.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset; abandons any request, flushes FIFO and read pipeline
//   bus   vrf_read_sequencer_if.master: request (start_i/vs_i/len_i/busy_o/done_o),
//         vrf port (raddr_o/ren_o/oreg_en_o/dout_i), stream (m_data_o/m_valid_o/m_last_o/m_ready_i)
module vrf_read_sequencer #(
  parameter int MEM_DEPTH    = 512,
  parameter int MEM_WIDTH    = 32,
  parameter int VREG_NUM     = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int LEN_W        = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  vrf_read_sequencer_if.master bus
);
  localparam int AW            = $clog2(MEM_DEPTH);
  localparam int ROWS_PER_VREG = MEM_DEPTH / VREG_NUM;
  localparam int PW            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW            = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]           base, raddr_last, raddr_cur;
  logic [LEN_W-1:0]        idx, len;
  logic [READ_LATENCY-1:0] rd_pipe, last_pipe;
  logic [MEM_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;
  logic [PW-1:0]           wptr, rptr;
  logic [CW-1:0]           fifo_count, inflight;
  logic                    done_q;
  logic                    accept, ren, issue_last, push, pop, pop_last, credit_ok;

  assign accept     = (state == S_IDLE) && bus.start_i;
  assign raddr_cur  = base + AW'(idx);
  assign issue_last = ren && (idx == len - 1'b1);
  // Data for a read issued READ_LATENCY cycles ago is on dout_i this cycle.
  assign push       = rd_pipe[READ_LATENCY-1];
  assign pop        = (fifo_count != '0) && bus.m_ready_i;
  assign pop_last   = pop && fifo_last[rptr];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(rd_pipe[i]);
  end

  // Pops in this cycle are not credited, so the sum equals reads issued minus beats already taken.
  assign credit_ok = (fifo_count + inflight) < CW'(FIFO_DEPTH);
  assign ren       = (state == S_ISSUE) && credit_ok;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start_i && bus.len_i != '0) state_nxt = S_ISSUE;
      S_ISSUE: if (issue_last) state_nxt = S_DRAIN;
      S_DRAIN: if (pop_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.busy_o    = (state != S_IDLE);
    bus.ren_o     = ren;
    // Address only moves when a read is issued; otherwise the last issued row is held.
    bus.raddr_o   = ren ? raddr_cur : raddr_last;
    bus.oreg_en_o = rd_pipe[READ_LATENCY-2];
    bus.done_o    = done_q;
    bus.m_valid_o = (fifo_count != '0);
    bus.m_data_o  = fifo_data[rptr];
    bus.m_last_o  = (fifo_count != '0) && fifo_last[rptr];
  end

  // Request bookkeeping and read pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base       <= '0;
      idx        <= '0;
      len        <= '0;
      raddr_last <= '0;
      rd_pipe    <= '0;
      last_pipe  <= '0;
      done_q     <= 1'b0;
    end else begin
      if (accept) begin
        base <= AW'(bus.vs_i) * AW'(ROWS_PER_VREG);
        idx  <= '0;
        len  <= bus.len_i;
      end else if (ren) begin
        idx        <= idx + 1'b1;
        raddr_last <= raddr_cur;
      end
      rd_pipe   <= {rd_pipe[READ_LATENCY-2:0], ren};
      last_pipe <= {last_pipe[READ_LATENCY-2:0], issue_last};
      done_q    <= (accept && bus.len_i == '0) || pop_last;
    end
  end

  // FIFO control.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      fifo_last  <= '0;
    end else begin
      if (push) begin
        fifo_last[wptr] <= last_pipe[READ_LATENCY-1];
        wptr            <= (wptr == PW'(FIFO_DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= (rptr == PW'(FIFO_DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset; fifo_count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) fifo_data[wptr] <= bus.dout_i;
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rstn) fifo_count <= CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_vrf_read_sequencer.sv
// tb/tb_vrf_read_sequencer.sv - scoreboard bench for vrf_read_sequencer with a 2-cycle vrf model
module tb_vrf_read_sequencer;
  localparam int MEM_DEPTH = 512;
  localparam int ROWS      = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  vrf_read_sequencer_if bus ();
  vrf_read_sequencer dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // vrf model: ren registers the row, oreg_en registers the output.
  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] r1, r2;
  always @(posedge clk) begin
    if (bus.ren_o)     r1 <= mem[bus.raddr_o];
    if (bus.oreg_en_o) r2 <= r1;
  end
  assign bus.dout_i = r2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]  addr_q [$];
  logic [32:0] beat_q [$];

  int   iss_cnt, acc_cnt, outstanding;
  int   ren_cnt, first_ren, last_ren, valid_cnt, first_valid, beat_cnt, last_beat, done_cnt, done_cyc;
  bit   stall_seen, hold_pend, prev_ren;
  logic [32:0] hold_val;

  always @(negedge clk) begin
    if (!rstn) begin
      iss_cnt   = 0;
      acc_cnt   = 0;
      hold_pend = 0;
      prev_ren  = 0;
    end else begin
      outstanding = iss_cnt - acc_cnt;
      if (outstanding >= 4) stall_seen = 1;
      check_eq("oreg_en", bus.oreg_en_o, prev_ren);
      prev_ren = bus.ren_o;
      if (bus.busy_o && addr_q.size() > 0 && outstanding < 4)
        check_eq("ren_when_credit", bus.ren_o, 1);
      if (bus.ren_o) begin
        check_eq("credit", outstanding < 4, 1);
        if (addr_q.size() > 0) check_eq("raddr", bus.raddr_o, addr_q.pop_front());
        else check_eq("ren_unexpected", bus.ren_o, 0);
        if (ren_cnt == 0) first_ren = cyc;
        last_ren = cyc;
        ren_cnt++;
        iss_cnt++;
      end
      if (bus.m_valid_o) begin
        if (valid_cnt == 0) first_valid = cyc;
        valid_cnt++;
        if (hold_pend) check_eq("hold", {bus.m_last_o, bus.m_data_o}, hold_val);
        if (bus.m_ready_i) begin
          if (beat_q.size() > 0) check_eq("beat", {bus.m_last_o, bus.m_data_o}, beat_q.pop_front());
          else check_eq("beat_unexpected", bus.m_valid_o, 0);
          beat_cnt++;
          last_beat = cyc;
          acc_cnt++;
          hold_pend = 0;
        end else begin
          hold_pend = 1;
          hold_val  = {bus.m_last_o, bus.m_data_o};
        end
      end else if (hold_pend) begin
        check_eq("hold_valid", bus.m_valid_o, 1);
        hold_pend = 0;
      end
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("busy_at_done", bus.busy_o, 0);
      end
    end
  end

  task automatic clear_mon();
    ren_cnt = 0; valid_cnt = 0; beat_cnt = 0; done_cnt = 0;
    first_ren = -1; last_ren = -1; first_valid = -1; last_beat = -1; done_cyc = -1;
    stall_seen = 0;
  endtask

  task automatic load_expect(input int vs, input int len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (vs * ROWS + i) % MEM_DEPTH;
      addr_q.push_back(9'(a));
      beat_q.push_back({(i == len - 1), mem[a]});
    end
  endtask

  // mode 0: ready high, 1: ready low T+5..T+14, 2: random ready. mid: start_i vs=7 while busy.
  task automatic run_req(input int vs, input int len, input int mode, input bit mid);
    int e;
    clear_mon();
    load_expect(vs, len);
    bus.start_i = 1'b1;
    bus.vs_i    = 5'(vs);
    bus.len_i   = 8'(len);
    @(posedge clk); #1;
    e = cyc;
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      case (mode)
        1:       bus.m_ready_i = !(cyc >= e + 4 && cyc <= e + 13);
        2:       bus.m_ready_i = 1'($urandom_range(0, 1));
        default: bus.m_ready_i = 1'b1;
      endcase
      bus.start_i = mid && (cyc == e + 5);
      if (bus.start_i) begin
        bus.vs_i  = 5'd7;
        bus.len_i = 8'd5;
      end
      @(posedge clk); #1;
    end
    bus.start_i   = 1'b0;
    bus.m_ready_i = 1'b1;
    check_eq("done_seen", done_cnt, 1);
    if (len == 0) begin
      check_eq("len0_done_cyc", done_cyc, e);
      check_eq("len0_ren", ren_cnt, 0);
      check_eq("len0_valid", valid_cnt, 0);
    end else begin
      check_eq("done_after_last", done_cyc, last_beat + 1);
      check_eq("beat_count", beat_cnt, len);
      check_eq("ren_count", ren_cnt, len);
      check_eq("first_ren", first_ren, e);
      if (mode == 0) begin
        check_eq("first_valid", first_valid, e + 3);
        check_eq("last_beat", last_beat, e + 2 + len);
        check_eq("last_ren", last_ren, e + len - 1);
      end
      if (mode == 1) check_eq("stall_seen", stall_seen, 1);
    end
    check_eq("addr_q_empty", addr_q.size(), 0);
    check_eq("beat_q_empty", beat_q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("single_done", done_cnt, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},   bus.busy_o, 0);
    check_eq({tag, "_done"},   bus.done_o, 0);
    check_eq({tag, "_ren"},    bus.ren_o, 0);
    check_eq({tag, "_oreg"},   bus.oreg_en_o, 0);
    check_eq({tag, "_valid"},  bus.m_valid_o, 0);
    check_eq({tag, "_last"},   bus.m_last_o, 0);
    check_eq({tag, "_raddr"},  bus.raddr_o, 0);
  endtask

  initial begin
    int e;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = {16'hBEEF ^ 16'(i * 7), 16'(i)};
    rstn = 1'b0;
    bus.start_i = 1'b0; bus.vs_i = '0; bus.len_i = '0; bus.m_ready_i = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    run_req(3, 16, 0, 0);
    run_req(31, 32, 0, 0);
    run_req(10, 16, 1, 0);
    run_req(2, 0, 0, 0);
    run_req(1, 16, 0, 1);
    run_req(20, 40, 2, 0);

    // Reset in the middle of ISSUE.
    clear_mon();
    load_expect(5, 16);
    bus.start_i = 1'b1; bus.vs_i = 5'd5; bus.len_i = 8'd16;
    @(posedge clk); #1;
    e = cyc;
    bus.start_i = 1'b0;
    while (cyc < e + 4) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    addr_q.delete();
    beat_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_mon();
    repeat (6) begin @(posedge clk); #1; end
    check_eq("no_done_after_reset", done_cnt, 0);
    check_eq("no_valid_after_reset", valid_cnt, 0);
    run_req(0, 4, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
